// File: rtl/tdm_deserializer8_if.sv
// Serial-in strobes and parallel-out status of the TDM deserializer.
// The master drives the line side; the slave is the deserializer itself.
interface tdm_deserializer8_if #(
  parameter int WIDTH = 8
);
  localparam int SLOT_W = $clog2(WIDTH + 1);

  logic              iSerial;
  logic              iValid;
  logic              iSync;
  logic [WIDTH-1:0]  oData;
  logic [SLOT_W-1:0] oSlot;
  logic              oFrameValid;
  logic              oSyncErr;
  logic              oParityErr;

  modport master (
    output iSerial, iValid, iSync,
    input  oData, oSlot, oFrameValid, oSyncErr, oParityErr
  );

  modport slave (
    input  iSerial, iValid, iSync,
    output oData, oSlot, oFrameValid, oSyncErr, oParityErr
  );
endinterface

// File: rtl/tdm_deserializer8.sv
// Self-timed TDM slot deserializer: sync marks slot 0 and WIDTH slots form one word.
// Define PARITY_EN to append an even-parity slot after the data slots.
module tdm_deserializer8 #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  tdm_deserializer8_if.slave bus
);
  localparam int SLOT_W = $clog2(WIDTH + 1);
`ifdef PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  typedef enum logic [1:0] {HUNT, RECV, WAIT} state_t;

  state_t            state_q, state_d;
  logic [LAST-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;
`ifdef PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    data_d        = data_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef PARITY_EN
    parity_err_d  = 1'b0;
`endif
    if (bus.iValid) begin
      // A sync strobe always restarts at slot 0, whatever state the frame was in.
      if (bus.iSync) begin
        sync_err_d  = (state_q == RECV);
        shadow_d    = '0;
        shadow_d[0] = bus.iSerial;
        slot_d      = SLOT_W'(1);
        state_d     = RECV;
      end else begin
        case (state_q)
          HUNT: state_d = HUNT;
          WAIT: begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
          RECV: begin
            if (slot_q == SLOT_W'(LAST)) begin
`ifdef PARITY_EN
              if (^{bus.iSerial, shadow_q} == 1'b0) begin
                data_d        = shadow_q;
                frame_valid_d = 1'b1;
              end else begin
                parity_err_d  = 1'b1;
              end
`else
              data_d        = {bus.iSerial, shadow_q};
              frame_valid_d = 1'b1;
`endif
              slot_d  = '0;
              state_d = WAIT;
            end else begin
              for (int i = 0; i < LAST; i++) begin
                if (slot_q == SLOT_W'(i)) shadow_d[i] = bus.iSerial;
              end
              slot_d = slot_q + SLOT_W'(1);
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      data_q        <= {WIDTH{IDLE_LEVEL}};
      slot_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      data_q        <= data_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
`ifdef PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign bus.oData       = data_q;
  assign bus.oSlot       = slot_q;
  assign bus.oFrameValid = frame_valid_q;
  assign bus.oSyncErr    = sync_err_q;
`ifdef PARITY_EN
  assign bus.oParityErr  = parity_err_q;
`else
  assign bus.oParityErr  = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_deserializer8.sv
// Scoreboard bench for tdm_deserializer8: directed frames plus random line traffic
// against a frame-level reference model.
module tb_tdm_deserializer8;
  localparam int WIDTH  = 8;
  localparam int SLOT_W = $clog2(WIDTH + 1);
`ifdef PARITY_EN
  localparam int NSLOTS = WIDTH + 1;
  localparam bit PAR    = 1'b1;
`else
  localparam int NSLOTS = WIDTH;
  localparam bit PAR    = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [SLOT_W-1:0] slot;
    logic              fv;
    logic              se;
    logic              pe;
  } status_t;

  logic clk = 1'b0;
  logic rst;

  tdm_deserializer8_if #(.WIDTH(WIDTH)) bus ();

  tdm_deserializer8 #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  status_t          exp_q[$];
  logic [WIDTH-1:0] frame_q[$];
  int               total = 0;
  int               bad   = 0;

  // Frame-level model: bits collected since the last sync, plus whether we are
  // hunting for a sync or waiting for the next frame's sync.
  bit               m_hunt = 1'b1;
  bit               m_wait = 1'b0;
  int               m_got  = 0;
  logic [16:0]      m_bits = '0;
  logic [WIDTH-1:0] m_data = '1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic d);
    status_t e;
    @(negedge clk);
    rst         = r;
    bus.iValid  = v;
    bus.iSync   = s;
    bus.iSerial = d;
    e.fv = 1'b0;
    e.se = 1'b0;
    e.pe = 1'b0;
    if (r) begin
      m_hunt = 1'b1;
      m_wait = 1'b0;
      m_got  = 0;
      m_data = '1;
    end else if (v) begin
      if (s) begin
        if (!m_hunt && !m_wait) e.se = 1'b1;
        m_hunt    = 1'b0;
        m_wait    = 1'b0;
        m_bits    = '0;
        m_bits[0] = d;
        m_got     = 1;
      end else if (m_wait) begin
        e.se   = 1'b1;
        m_wait = 1'b0;
        m_hunt = 1'b1;
      end else if (!m_hunt) begin
        m_bits[m_got] = d;
        m_got++;
        if (m_got == NSLOTS) begin
          if (PAR && (^m_bits[NSLOTS-1:0])) begin
            e.pe = 1'b1;
          end else begin
            m_data = m_bits[WIDTH-1:0];
            e.fv   = 1'b1;
            frame_q.push_back(m_data);
          end
          m_got  = 0;
          m_wait = 1'b1;
        end
      end
    end
    e.data = m_data;
    e.slot = (m_hunt || m_wait) ? '0 : SLOT_W'(m_got);
    exp_q.push_back(e);
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] val, input bit bubbles, input bit bad_par);
    logic b;
    for (int i = 0; i < NSLOTS; i++) begin
      b = (i < WIDTH) ? val[i] : ((^val) ^ bad_par);
      applyStimulus(1'b0, 1'b1, (i == 0), b);
      if (bubbles) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom));
      end
    end
  endtask

  task automatic checkOutput(input status_t e);
    check("oData", 32'(bus.oData), 32'(e.data));
    check("oSlot", 32'(bus.oSlot), 32'(e.slot));
    check("oFrameValid", 32'(bus.oFrameValid), 32'(e.fv));
    check("oSyncErr", 32'(bus.oSyncErr), 32'(e.se));
    check("oParityErr", 32'(bus.oParityErr), 32'(e.pe));
  endtask

  // Monitor: samples just after each rising edge, independent of the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      if (bus.oFrameValid === 1'b1) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame", 32'(bus.oFrameValid), 32'd0);
        end else begin
          check("frame_data", 32'(bus.oData), 32'(frame_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic r, v, s;
    rst         = 1'b1;
    bus.iValid  = 1'b0;
    bus.iSync   = 1'b0;
    bus.iSerial = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    $display("[TB] frame 4D");
    sendFrame(8'h4D, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back A5, 3C");
    sendFrame(8'hA5, 1'b0, 1'b0);
    sendFrame(8'h3C, 1'b0, 1'b0);

    $display("[TB] FF with bubbles");
    sendFrame(8'hFF, 1'b1, 1'b0);

    $display("[TB] premature sync");
    sendFrame(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, (i == 0), 1'b1);
    sendFrame(8'h22, 1'b0, 1'b0);

    $display("[TB] WAIT without sync");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, (i == 0), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'(i));

`ifdef PARITY_EN
    $display("[TB] parity good/bad");
    sendFrame(8'h4D, 1'b0, 1'b0);
    sendFrame(8'hB2, 1'b0, 1'b1);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_hunt || m_wait) s = ($urandom_range(0, 9) != 0);
      else s = ($urandom_range(0, 29) == 0);
      applyStimulus(r, v, s, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("status_queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_queue_drained", 32'(frame_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
